// File: rtl/soc_pio_bidir.sv
// Avalon-MM parallel I/O slave: per-bit direction, synchronised inputs, atomic set/clear of data_out.
// Optional edge-capture interrupts are built when SOC_PIO_EDGE_CAPTURE_EN is defined.
module soc_pio_bidir #(
    parameter int unsigned      WIDTH       = 8,
    parameter int unsigned      EDGE_TYPE   = 0,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] oe,
    output logic             irq
);

    localparam logic [2:0] AddrData     = 3'd0;
    localparam logic [2:0] AddrDir      = 3'd1;
    localparam logic [2:0] AddrIrqMask  = 3'd2;
    localparam logic [2:0] AddrEdgeCap  = 3'd3;
    localparam logic [2:0] AddrOutSet   = 3'd4;
    localparam logic [2:0] AddrOutClear = 3'd5;

    logic             wr_en;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic [WIDTH-1:0] oe_q, oe_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [31:0]      rdata_q, rdata_d;
    logic [WIDTH-1:0] ec_rd;
    logic             unused_writedata;

    assign wr_en            = chipselect & ~write_n;
    assign wdata            = writedata[WIDTH-1:0];
    assign unused_writedata = ^(writedata >> WIDTH);

    always_comb begin
        data_out_d = data_out_q;
        oe_d       = oe_q;
        mask_d     = mask_q;
        if (wr_en) begin
            case (address)
                AddrData:     data_out_d = wdata;
                AddrDir:      oe_d       = wdata;
                AddrIrqMask:  mask_d     = wdata;
                AddrOutSet:   data_out_d = data_out_q | wdata;
                AddrOutClear: data_out_d = data_out_q & ~wdata;
                default:      ;
            endcase
        end
    end

    // Read data is refreshed every cycle from the current address, independent of chipselect.
    always_comb begin
        rdata_d = '0;
        case (address)
            AddrData:    rdata_d[WIDTH-1:0] = (sync2_q & ~oe_q) | (data_out_q & oe_q);
            AddrDir:     rdata_d[WIDTH-1:0] = oe_q;
            AddrIrqMask: rdata_d[WIDTH-1:0] = mask_q;
            AddrEdgeCap: rdata_d[WIDTH-1:0] = ec_rd;
            default:     ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_out_q <= RESET_VALUE;
            oe_q       <= '0;
            mask_q     <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            rdata_q    <= '0;
        end else begin
            data_out_q <= data_out_d;
            oe_q       <= oe_d;
            mask_q     <= mask_d;
            sync1_q    <= in_port;
            sync2_q    <= sync1_q;
            rdata_q    <= rdata_d;
        end
    end

`ifdef SOC_PIO_EDGE_CAPTURE_EN
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] ec_q, ec_d;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] ec_clr;

    always_comb begin
        case (EDGE_TYPE)
            0:       edge_det = sync2_q & ~prev_q;
            1:       edge_det = ~sync2_q & prev_q;
            default: edge_det = sync2_q ^ prev_q;
        endcase
        ec_clr = (wr_en && address == AddrEdgeCap) ? wdata : '0;
        // A fresh edge overrides a same-cycle clear of that bit.
        ec_d   = (ec_q & ~ec_clr) | edge_det;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= '0;
            ec_q   <= '0;
        end else begin
            prev_q <= sync2_q;
            ec_q   <= ec_d;
        end
    end

    assign ec_rd = ec_q;
    assign irq   = |(ec_q & mask_q);
`else
    logic [1:0] unused_edge_type;

    assign unused_edge_type = 2'(EDGE_TYPE);
    assign ec_rd            = '0;
    assign irq              = |(sync2_q & mask_q);
`endif

    assign readdata = rdata_q;
    assign out_port = data_out_q;
    assign oe       = oe_q;

endmodule

// File: tb/tb_soc_pio_bidir.sv
// Directed bench for soc_pio_bidir: a rising-edge instance and a falling-edge instance share one bus.
module tb_soc_pio_bidir;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_port;
    logic [31:0] readdata_r, readdata_f;
    logic [7:0]  out_port_r, out_port_f, oe_r, oe_f;
    logic        irq_r, irq_f;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    soc_pio_bidir #(.WIDTH(8), .EDGE_TYPE(0), .RESET_VALUE(8'hA5)) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata_r),
        .in_port    (in_port),
        .out_port   (out_port_r),
        .oe         (oe_r),
        .irq        (irq_r)
    );

    soc_pio_bidir #(.WIDTH(8), .EDGE_TYPE(1), .RESET_VALUE(8'h00)) dut_f (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata_f),
        .in_port    (in_port),
        .out_port   (out_port_f),
        .oe         (oe_f),
        .irq        (irq_f)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic bus_rd(input logic [2:0] a);
        address = a;
        tick(1);
    endtask

    initial begin
        reset      = 1'b1;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = '0;

        tick(3);
        check_eq("rst_readdata", readdata_r, 32'h0);
        check_eq("rst_out_port", {24'h0, out_port_r}, 32'hA5);
        check_eq("rst_out_port_f", {24'h0, out_port_f}, 32'h00);
        check_eq("rst_oe", {24'h0, oe_r}, 32'h0);
        check_eq("rst_irq", {31'h0, irq_r}, 32'h0);
        reset = 1'b0;
        for (int a = 0; a < 8; a++) begin
            bus_rd(3'(a));
            check_eq($sformatf("rst_rd%0d", a), readdata_r, 32'h0);
        end

        // Set/clear sequence; upper writedata bits must be ignored.
        bus_wr(3'd0, 32'hFFFF_FF0F);
        check_eq("wr_data", {24'h0, out_port_r}, 32'h0F);
        bus_wr(3'd4, 32'h0000_00F0);
        check_eq("outset", {24'h0, out_port_r}, 32'hFF);
        bus_wr(3'd5, 32'h0000_0081);
        check_eq("outclear", {24'h0, out_port_r}, 32'h7E);
        bus_rd(3'd4);
        check_eq("rd_outset", readdata_r, 32'h0);
        bus_rd(3'd5);
        check_eq("rd_outclear", readdata_r, 32'h0);

        // Mixed direction
        bus_wr(3'd1, 32'hF0);
        check_eq("oe", {24'h0, oe_r}, 32'hF0);
        bus_wr(3'd0, 32'hAA);
        in_port = 8'h55;
        tick(3);
        bus_rd(3'd0);
        check_eq("rd_mixed", readdata_r, 32'h0000_00A5);
        bus_rd(3'd1);
        check_eq("rd_dir", readdata_r, 32'hF0);
        bus_wr(3'd6, 32'hFF);
        bus_rd(3'd6);
        check_eq("rd_rsvd6", readdata_r, 32'h0);
        check_eq("rsvd_no_effect", {16'h0, oe_r, out_port_r}, 32'h0000_F0AA);
        check_eq("irq_unmasked", {30'h0, irq_r, irq_f}, 32'h0);

`ifdef SOC_PIO_EDGE_CAPTURE_EN
        bus_rd(3'd3);
        check_eq("ec_rise_55", readdata_r, 32'h55);
        check_eq("ec_fall_none", readdata_f, 32'h0);
        in_port = 8'h00;
        tick(4);
        bus_rd(3'd3);
        check_eq("ec_rise_hold", readdata_r, 32'h55);
        check_eq("ec_fall_55", readdata_f, 32'h55);
        bus_wr(3'd3, 32'hFF);
        bus_rd(3'd3);
        check_eq("ec_w1c", readdata_r, 32'h0);
        check_eq("ec_w1c_f", readdata_f, 32'h0);

        // Rising-edge irq: in_port[0] changes at edge N, irq at edge N+3
        bus_wr(3'd2, 32'h01);
        in_port = 8'h01;
        tick(1);
        check_eq("irq_n1", {31'h0, irq_r}, 32'h0);
        tick(1);
        check_eq("irq_n2", {31'h0, irq_r}, 32'h0);
        tick(1);
        check_eq("irq_n3", {31'h0, irq_r}, 32'h1);
        check_eq("irq_n3_f", {31'h0, irq_f}, 32'h0);
        bus_rd(3'd3);
        check_eq("ec_bit0", readdata_r, 32'h1);
        bus_wr(3'd3, 32'h01);
        check_eq("irq_cleared", {31'h0, irq_r}, 32'h0);

        // Clear/edge collision on bit 2 in the falling-edge instance
        in_port = 8'h05;
        tick(5);
        bus_wr(3'd3, 32'hFF);
        in_port = 8'h01;
        tick(2);
        address    = 3'd3;
        writedata  = 32'h04;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
        bus_rd(3'd3);
        check_eq("collide_f", readdata_f, 32'h04);
        check_eq("collide_r", readdata_r, 32'h0);
`else
        in_port = 8'h00;
        tick(4);
        bus_wr(3'd2, 32'h02);
        bus_rd(3'd2);
        check_eq("rd_mask", readdata_r, 32'h02);
        in_port = 8'h02;
        tick(1);
        check_eq("lvl_n1", {31'h0, irq_r}, 32'h0);
        tick(1);
        check_eq("lvl_n2", {30'h0, irq_r, irq_f}, 32'h3);
        tick(3);
        check_eq("lvl_hold", {31'h0, irq_r}, 32'h1);
        in_port = 8'h00;
        tick(1);
        check_eq("lvl_m1", {31'h0, irq_r}, 32'h1);
        tick(1);
        check_eq("lvl_m2", {31'h0, irq_r}, 32'h0);
        bus_wr(3'd3, 32'hFF);
        bus_rd(3'd3);
        check_eq("rd_addr3", readdata_r, 32'h0);
`endif

        // Reset overrides a same-cycle write
        reset      = 1'b1;
        address    = 3'd0;
        writedata  = 32'h0;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
        check_eq("rst_over_wr", {24'h0, out_port_r}, 32'hA5);
        check_eq("rst_over_oe", {24'h0, oe_r}, 32'h0);
        check_eq("rst_over_irq", {31'h0, irq_r}, 32'h0);
        reset = 1'b0;
        tick(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
